// File: rtl/dmem_responder.sv
// Data-memory responder for a MEM stage: one access in flight, a programmable
// wait period, then a held response carrying extended load data or a fault flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a response holds until taken.
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [3:0]       wr_be;
    logic [31:0]      wr_lanes;
    logic [31:0]      wr_word;
    logic             mem_we;

    assign idx     = addr_q[IDX_W+1:2];
    assign rd_word = mem_q[idx];

    always_comb begin
        acc_err = (size_q > 3'd2)
               || (size_q == 3'd1 && addr_q[0])
               || (size_q == 3'd2 && addr_q[1:0] != 2'b00)
               || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    end

    // Little-endian lane extraction from the addressed word.
    always_comb begin
        byte_v = 8'(rd_word >> {addr_q[1:0], 3'b000});
        half_v = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            3'd0:    ld_data = sign_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            3'd1:    ld_data = sign_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
            default: ld_data = rd_word;
        endcase
    end

    // Read-modify-write merge so untouched bytes keep their old value.
    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = wdata_q;
        case (size_q)
            3'd0: begin
                wr_be    = 4'b0001 << addr_q[1:0];
                wr_lanes = {4{wdata_q[7:0]}};
            end
            3'd1: begin
                wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            3'd2:    wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
        for (int b = 0; b < 4; b++) begin
            wr_word[8*b +: 8] = wr_be[b] ? wr_lanes[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    sign_d  = req_sign;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || store_q) ? 32'h0 : ld_data;
                    mem_we  = store_q && !acc_err && !rst;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            store_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 3'd0;
            sign_q  <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array itself is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences,
// then random accesses checked against a byte-array memory model.
module tb_dmem_responder;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH_WORDS = 1024;
    localparam int LAT = WAIT_CYCLES + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_size = 3'd0;
    logic        req_sign = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m   [DEPTH_WORDS*4];
    bit         known_m [DEPTH_WORDS*4];

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        bit          sign;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [16];

    dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_sign(req_sign),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference model: byte-addressed memory, fault rules applied directly.
    function automatic void model(input bit st, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] sz, input bit sg,
                                  output logic [31:0] rd, output bit e, output bit known);
        int n;
        int base;
        logic [31:0] val;
        n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        e = (sz > 3'd2) || (sz == 3'd1 && a % 2 != 0) || (sz == 3'd2 && a % 4 != 0)
            || (a / 4 >= DEPTH_WORDS);
        rd = 32'h0;
        known = 1'b1;
        if (e) return;
        base = int'(a);
        if (st) begin
            for (int i = 0; i < n; i++) begin
                mem_m[base+i]   = 8'((wd >> (8*i)) & 32'hFF);
                known_m[base+i] = 1'b1;
            end
        end else begin
            val = 32'h0;
            for (int i = 0; i < n; i++) begin
                val = val | (32'(mem_m[base+i]) << (8*i));
                known = known & known_m[base+i];
            end
            if (sg && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
            rd = val;
        end
    endfunction

    task automatic drive_req(input bit st, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] sz, input bit sg, input bit drop);
        int n;
        @(negedge clk);
        req_store = st; req_addr = a; req_wdata = wd; req_size = sz; req_sign = sg;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        if (drop) begin
            req_valid = 1'b0;
            req_store = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_size  = 3'($urandom);
            req_sign  = 1'($urandom);
        end
    endtask

    task automatic collect_resp(input int hold, output logic [31:0] rd, output logic e, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 60);
        if (!resp_valid) begin
            chk("resp_timeout", 32'(resp_valid), 32'h1);
            rd = 32'h0;
            e = 1'b0;
            return;
        end
        rd = resp_rdata;
        e  = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'h1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err", 32'(resp_err), 32'(e));
            chk("hold_req_ready", 32'(req_ready), 32'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_valid", 32'(resp_valid), 32'h0);
        chk("post_rdata", resp_rdata, 32'h0);
        chk("post_err", 32'(resp_err), 32'h0);
    endtask

    task automatic access(input bit st, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] sz, input bit sg, input int hold,
                          output logic [31:0] rd, output logic e, output int lat,
                          output logic [31:0] exp_rd, output bit exp_e, output bit known);
        model(st, a, wd, sz, sg, exp_rd, exp_e, known);
        drive_req(st, a, wd, sz, sg, 1'b1);
        collect_resp(hold, rd, e, lat);
    endtask

    initial begin
        logic [31:0] rd, exp_rd, a;
        logic        e;
        bit          exp_e, known;
        int          lat, n, first_acc, second_acc;
        logic [2:0]  sz;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'd2, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        3'd2, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h11,  32'hAAAAAA7F, 3'd0, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        3'd2, 1'b0, 32'hDEAD7FEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,  32'h0,        3'd0, 1'b1, 32'hFFFFFFDE, 1'b0};
        vecs[5]  = '{1'b0, 32'h12,  32'h0,        3'd1, 1'b0, 32'h0000DEAD, 1'b0};
        vecs[6]  = '{1'b0, 32'h12,  32'h0,        3'd2, 1'b0, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h11,  32'h00001234, 3'd1, 1'b0, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h10,  32'h0,        3'd3, 1'b0, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h1000, 32'h0,       3'd2, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h10,  32'h0,        3'd2, 1'b0, 32'hDEAD7FEF, 1'b0};
        vecs[11] = '{1'b0, 32'h11,  32'h0,        3'd0, 1'b1, 32'h0000007F, 1'b0};
        vecs[12] = '{1'b0, 32'h10,  32'h0,        3'd1, 1'b1, 32'h00007FEF, 1'b0};
        vecs[13] = '{1'b0, 32'h12,  32'h0,        3'd1, 1'b1, 32'hFFFFDEAD, 1'b0};
        vecs[14] = '{1'b1, 32'hFFC, 32'hCAFEF00D, 3'd2, 1'b0, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'hFFC, 32'h0,        3'd2, 1'b0, 32'hCAFEF00D, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            access(vecs[i].st, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign, 0,
                   rd, e, lat, exp_rd, exp_e, known);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
        end

        // Held response with req_valid kept high throughout
        drive_req(1'b0, 32'h10, 32'h0, 3'd2, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            chk("busy_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(resp_valid), 32'h1);
            chk("stall_rdata", resp_rdata, 32'hDEAD7FEF);
            chk("stall_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("stall_release_valid", 32'(resp_valid), 32'h0);
        chk("stall_release_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        collect_resp(0, rd, e, lat);
        chk("stall_next_rdata", rd, 32'hDEAD7FEF);
        chk("stall_next_latency", 32'(lat), 32'(LAT));

        // Back-to-back acceptance spacing
        first_acc = -1;
        second_acc = -1;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h10; req_size = 3'd2; req_sign = 1'b0;
        resp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (req_ready && req_valid) begin
                if (first_acc < 0) first_acc = c;
                else if (second_acc < 0) second_acc = c;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n = 0;
        while ((!req_ready || resp_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        resp_ready = 1'b0;
        chk("accept_spacing", 32'(second_acc - first_acc), 32'(WAIT_CYCLES + 3));

        // Reset during WAIT drops the pending store
        access(1'b1, 32'h20, 32'h0, 3'd2, 1'b0, 0, rd, e, lat, exp_rd, exp_e, known);
        drive_req(1'b1, 32'h20, 32'h12345678, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        chk("pre_rst_in_wait", 32'(resp_valid), 32'h0);
        rst = 1'b1;
        #1;
        chk("wait_rst_req_ready", 32'(req_ready), 32'h0);
        chk("wait_rst_valid", 32'(resp_valid), 32'h0);
        chk("wait_rst_rdata", resp_rdata, 32'h0);
        chk("wait_rst_err", 32'(resp_err), 32'h0);
        repeat (2) @(negedge clk);
        chk("wait_rst_valid2", 32'(resp_valid), 32'h0);
        chk("wait_rst_req_ready2", 32'(req_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("wait_rst_release_ready", 32'(req_ready), 32'h1);
        access(1'b0, 32'h20, 32'h0, 3'd2, 1'b0, 0, rd, e, lat, exp_rd, exp_e, known);
        chk("dropped_store_rdata", rd, 32'h0);
        chk("dropped_store_neq", 32'(rd == 32'h12345678), 32'h0);
        chk("dropped_store_err", 32'(e), 32'h0);

        // Random phase: preload a region, then mixed accesses against the model
        for (int w = 0; w < 64; w++) begin
            access(1'b1, 32'(w*4), $urandom, 3'd2, 1'b0, 0, rd, e, lat, exp_rd, exp_e, known);
        end
        access(1'b1, 32'hFF8, $urandom, 3'd2, 1'b0, 0, rd, e, lat, exp_rd, exp_e, known);
        access(1'b1, 32'hFFC, $urandom, 3'd2, 1'b0, 0, rd, e, lat, exp_rd, exp_e, known);
        for (int k = 0; k < 200; k++) begin
            n = $urandom_range(0, 9);
            if (n < 8) a = 32'($urandom_range(0, 255));
            else if (n == 8) a = 32'($urandom_range(4088, 4200));
            else a = $urandom;
            sz = ($urandom_range(0, 7) < 7) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            access(1'($urandom), a, $urandom, sz, 1'($urandom), $urandom_range(0, 3),
                   rd, e, lat, exp_rd, exp_e, known);
            chk("rand_err", 32'(e), 32'(exp_e));
            if (known) chk("rand_rdata", rd, exp_rd);
            chk("rand_latency", 32'(lat), 32'(LAT));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal data array.
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait states between request acceptance and response (legal range 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  MEM-stage access request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_store  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data; the value is taken from its low-order bits per size.
REQ-010 req_size  input  3  0 = byte, 1 = halfword, 2 = word; 3..7 are illegal.
REQ-011 req_sign  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  requester accepts response.
REQ-014 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  access faulted.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-017 On req_valid && req_ready at edge N, all req_* fields SHALL be captured, and the FSM SHALL enter WAIT with the counter loaded to WAIT_CYCLES.
REQ-018 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to RESP at the edge where the counter is 0 (WAIT_CYCLES=0 gives one WAIT cycle).
REQ-019 resp_valid SHALL first be high in the cycle after edge N+1+WAIT_CYCLES.
REQ-020 Request fields SHALL be ignored outside the acceptance edge; a changed req_* after acceptance SHALL have no effect.
REQ-021 An error SHALL be flagged for any of these conditions: req_size > 2; a halfword with addr[0]=1; a word with addr[1:0]!=0; or addr[31:2] >= DEPTH_WORDS.
REQ-022 The array SHALL be little-endian; the byte lane is addr[1:0] and the halfword lane is addr[1].
REQ-023 A store SHALL update only the addressed bytes at the WAIT->RESP edge; all other bytes SHALL be preserved.
REQ-024 A faulting store SHALL write nothing.
REQ-025 A load SHALL read the array at the WAIT->RESP edge; resp_rdata SHALL be the extracted lane, extended according to the captured req_sign.
REQ-026 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1.
REQ-027 At that handshake edge, the FSM SHALL return to IDLE, and resp_valid, resp_rdata and resp_err SHALL be 0 in the next cycle.
REQ-028 No new request SHALL be accepted in the cycle resp_valid falls; the minimum spacing between acceptances is WAIT_CYCLES+3 cycles.
REQ-029 resp_ready outside RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored.

Reset
REQ-030 While rst=1: state = IDLE, counter = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-031 An rst assertion in WAIT SHALL discard the in-flight access; a pending store SHALL NOT be written.
REQ-032 Array contents SHALL NOT be reset; reading an unwritten location returns an undefined value with resp_err = 0.
REQ-033 In the first cycle after rst deasserts, req_ready = 1.

Verification (WAIT_CYCLES=2, DEPTH_WORDS=1024)
REQ-034 Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid first high 4 cycles after acceptance.
REQ-035 After REQ-034, byte store 0x7F to 0x11, then word load 0x10 -> 0xDEAD7FEF; signed byte load 0x13 -> 0xFFFFFFDE; unsigned halfword load 0x12 -> 0x0000DEAD.
REQ-036 Word load 0x12, halfword store 0x11, size=3 load, and word load 0x1000 -> each gives resp_err=1 and resp_rdata=0; a following word load 0x10 returns 0xDEAD7FEF (no corruption).
REQ-037 Load response with resp_ready held 0 for 5 cycles -> resp_valid/rdata stable all 5 cycles; req_valid held 1 throughout is not accepted until IDLE.
REQ-038 Accept word store 0x12345678 to 0x20, assert rst during WAIT, release, load 0x20 -> value differs from 0x12345678 when pre-initialised to 0 (store dropped); all outputs 0 during rst.
